hum_fan_ctrl: RTL and testbench

Humidity-driven fan/humidifier controller between the DHT11 receiver and the motor PWM output. It converts each integer humidity sample into a target duty band, applying hysteresis between bands. It ramps the applied duty toward that target once per PWM period, which gives soft start and soft stop. It forces the output off on sensor error or stale data, and exports state, fault and duty for the I2C LCD status page.

---
 rtl/hum_pkg.sv | 54 +++++
 rtl/hum_fan_ctrl_if.sv | 21 ++
 rtl/pwm_core.sv | 43 ++++
 rtl/hum_fan_ctrl.sv | 127 ++++++++++++
 tb/tb_hum_fan_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hum_pkg.sv
// Shared encodings and band tables for the humidity fan controller.
// Pure definitions; no logic, latency or flow control of its own.
package hum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } band_t;

  localparam int EDGE_B3 = 20;
  localparam int EDGE_B2 = 40;
  localparam int EDGE_B1 = 60;

  localparam int PCT_B3 = 80;
  localparam int PCT_B2 = 50;
  localparam int PCT_B1 = 20;

  localparam int HUM_MAX = 100;

  function automatic band_t raw_band(input logic [7:0] h);
    if (int'(h) < EDGE_B3)      return B3;
    else if (int'(h) < EDGE_B2) return B2;
    else if (int'(h) < EDGE_B1) return B1;
    else                        return B0;
  endfunction

  // B0 has no lower band, so its edge is placed out of reach.
  function automatic int band_upper(input band_t b);
    case (b)
      B3:      return EDGE_B3;
      B2:      return EDGE_B2;
      B1:      return EDGE_B1;
      default: return 1024;
    endcase
  endfunction

  function automatic int band_target(input band_t b, input int period);
    case (b)
      B3:      return period * PCT_B3 / 100;
      B2:      return period * PCT_B2 / 100;
      B1:      return period * PCT_B1 / 100;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/hum_fan_ctrl_if.sv
// Sample-in / status-out bundle between the DHT11 receiver, the controller and the LCD page.
// Strobes are single-cycle; there is no backpressure on any signal.
interface hum_fan_ctrl_if;
  logic       hum_valid;
  logic [7:0] hum_int;
  logic       sensor_err;
  logic       pwm;
  logic [9:0] duty;
  logic [1:0] state;
  logic       fault;

  modport master (
    output hum_valid, hum_int, sensor_err,
    input  pwm, duty, state, fault
  );

  modport slave (
    input  hum_valid, hum_int, sensor_err,
    output pwm, duty, state, fault
  );
endinterface

// File: rtl/pwm_core.sv
// Free-running period counter with registered PWM; duty is latched only on the boundary edge.
// pwm equals (counter < duty) in the same cycle as the counter; no backpressure.
module pwm_core #(
  parameter int PERIOD = 1000,
  parameter int DW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_duty,
  output logic          o_bnd,
  output logic          o_pwm,
  output logic [DW-1:0] o_duty
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] w_duty_nxt;
  logic          r_pwm;

  assign o_bnd      = (r_cnt == CW'(PERIOD - 1));
  assign w_cnt_nxt  = o_bnd ? '0 : r_cnt + CW'(1);
  assign w_duty_nxt = o_bnd ? i_duty : r_duty;

  // Compare on next-state values so the registered pwm lines up with the counter it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_duty <= w_duty_nxt;
      r_pwm  <= (32'(w_cnt_nxt) < 32'(w_duty_nxt));
    end
  end

  assign o_pwm  = r_pwm;
  assign o_duty = r_duty;

endmodule

// File: rtl/hum_fan_ctrl.sv
// Humidity band/hysteresis FSM with soft-ramped fan duty, stale-sample watchdog and fault handling.
// Samples register in one edge; duty moves only at period boundaries; no backpressure.
module hum_fan_ctrl
  import hum_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int RAMP_STEP   = 10,
  parameter int HYST        = 2,
  parameter int TIMEOUT_PER = 4000
) (
  input  logic          clk,
  input  logic          rst,
  hum_fan_ctrl_if.slave bus
);

  localparam int DW = 10;
  localparam int SW = $clog2(TIMEOUT_PER + 1);

  state_t        r_state, w_state_nxt;
  band_t         r_band, w_band_nxt;
  band_t         w_raw, w_hyst_band;
  logic [SW-1:0] r_stale, w_stale_nxt;
  logic          w_good, w_bad, w_bnd, w_pwm;
  logic [DW-1:0] w_duty, w_duty_nxt, w_tgt, w_step;

  assign w_bad  = bus.sensor_err | (bus.hum_valid & (int'(bus.hum_int) > HUM_MAX));
  assign w_good = bus.hum_valid & ~bus.sensor_err & (int'(bus.hum_int) <= HUM_MAX);
  assign w_raw  = raw_band(bus.hum_int);

  // Drier samples win at once; wetter ones must clear the current band's edge by HYST.
  always_comb begin
    w_hyst_band = r_band;
    if (w_raw > r_band)
      w_hyst_band = w_raw;
    else if ((w_raw < r_band) && (int'(bus.hum_int) >= band_upper(r_band) + HYST))
      w_hyst_band = w_raw;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_band_nxt  = r_band;
    w_stale_nxt = r_stale;
    case (r_state)
      ST_IDLE: begin
        if (w_good) begin
          w_state_nxt = ST_RUN;
          w_band_nxt  = w_raw;
          w_stale_nxt = '0;
        end
      end
      ST_RUN: begin
        if (w_bad) begin
          w_state_nxt = ST_FAULT;
          w_band_nxt  = B0;
        end else if (w_good) begin
          w_band_nxt  = w_hyst_band;
          w_stale_nxt = '0;
        end else if (w_bnd) begin
          if (r_stale >= SW'(TIMEOUT_PER - 1)) begin
            w_stale_nxt = SW'(TIMEOUT_PER);
            w_state_nxt = ST_FAULT;
            w_band_nxt  = B0;
          end else begin
            w_stale_nxt = r_stale + SW'(1);
          end
        end
      end
      ST_FAULT: begin
        w_band_nxt = B0;
        if (w_good) begin
          w_state_nxt = ST_RUN;
          w_band_nxt  = w_raw;
          w_stale_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_band_nxt  = B0;
        w_stale_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_band  <= B0;
      r_stale <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_band  <= w_band_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  // Built from registered state only, so a strobe in the boundary cycle cannot affect that boundary.
  assign w_tgt  = (r_state == ST_RUN) ? DW'(band_target(r_band, PERIOD)) : '0;
  assign w_step = DW'(RAMP_STEP);

  always_comb begin
    w_duty_nxt = w_duty;
    if (r_state == ST_FAULT)
      w_duty_nxt = '0;
    else if (w_tgt > w_duty)
      w_duty_nxt = ((w_tgt - w_duty) > w_step) ? (w_duty + w_step) : w_tgt;
    else if (w_tgt < w_duty)
      w_duty_nxt = ((w_duty - w_tgt) > w_step) ? (w_duty - w_step) : w_tgt;
  end

  pwm_core #(
    .PERIOD (PERIOD),
    .DW     (DW)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .i_duty (w_duty_nxt),
    .o_bnd  (w_bnd),
    .o_pwm  (w_pwm),
    .o_duty (w_duty)
  );

  assign bus.pwm   = w_pwm;
  assign bus.duty  = w_duty;
  assign bus.state = r_state;
  assign bus.fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_hum_fan_ctrl.sv
// Period-level scoreboard bench for hum_fan_ctrl (scaled PERIOD so long ramps stay short).
module tb_hum_fan_ctrl;

  localparam int P    = 100;
  localparam int STEP = 1;
  localparam int HY   = 2;
  localparam int TO   = 5;

  logic clk = 1'b0;
  logic rst;

  hum_fan_ctrl_if bus ();

  hum_fan_ctrl #(
    .PERIOD      (P),
    .RAMP_STEP   (STEP),
    .HYST        (HY),
    .TIMEOUT_PER (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  int m_state, m_band, m_duty, m_stale;
  int exp_duty_q[$];
  int exp_st_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int raw_b(input int h);
    if (h < 20) return 3;
    if (h < 40) return 2;
    if (h < 60) return 1;
    return 0;
  endfunction

  function automatic int up_b(input int b);
    case (b)
      3: return 20;
      2: return 40;
      1: return 60;
      default: return 1000;
    endcase
  endfunction

  function automatic int tgt_b(input int b);
    case (b)
      3: return P * 80 / 100;
      2: return P * 50 / 100;
      1: return P * 20 / 100;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_band = 0; m_duty = 0; m_stale = 0;
  endtask

  task automatic model_event(input bit v, input bit e, input int h);
    bit good, bad;
    int rb;
    bad  = e || (v && h > 100);
    good = v && !e && h <= 100;
    rb   = raw_b(h);
    case (m_state)
      1: begin
        if (bad) begin
          m_state = 2; m_band = 0;
        end else if (good) begin
          m_stale = 0;
          if (rb > m_band) m_band = rb;
          else if (rb < m_band && h >= up_b(m_band) + HY) m_band = rb;
        end
      end
      default: begin
        if (good) begin
          m_state = 1; m_band = rb; m_stale = 0;
        end
      end
    endcase
  endtask

  task automatic model_boundary();
    int t;
    t = (m_state == 1) ? tgt_b(m_band) : 0;
    if (m_state == 2)    m_duty = 0;
    else if (t > m_duty) m_duty = (m_duty + STEP > t) ? t : m_duty + STEP;
    else if (t < m_duty) m_duty = (m_duty - STEP < t) ? t : m_duty - STEP;
    if (m_state == 1) begin
      m_stale++;
      if (m_stale >= TO) begin
        m_state = 2; m_band = 0;
      end
    end
  endtask

  // One full PWM period starting at counter==0; optional strobe at cycle ev_c (-1 = none).
  task automatic run_period(input int ev_c, input bit v, input bit e, input int h);
    int hi, st, ed;
    logic [31:0] d0;
    hi = 0;
    d0 = '0;
    exp_duty_q.push_back(m_duty);
    chk("state", bus.state, m_state);
    chk("fault", bus.fault, (m_state == 2));
    for (int c = 0; c < P; c++) begin
      hi += int'(bus.pwm);
      if (c == 0) d0 = 32'(bus.duty);
      if (c == ev_c + 1 && exp_st_q.size() > 0) begin
        st = exp_st_q.pop_front();
        chk("state_next", bus.state, st);
        chk("fault_next", bus.fault, (st == 2));
      end
      bus.hum_valid  = (c == ev_c) && v;
      bus.sensor_err = (c == ev_c) && e;
      bus.hum_int    = (c == ev_c) ? 8'(h) : 8'd0;
      if (c == ev_c) begin
        model_event(v, e, h);
        exp_st_q.push_back(m_state);
      end
      @(negedge clk);
    end
    model_boundary();
    ed = exp_duty_q.pop_front();
    chk("duty", d0, ed);
    chk("pwm_hi", hi, ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst            = 1'b0;
    bus.hum_valid  = 1'b0;
    bus.sensor_err = 1'b0;
    bus.hum_int    = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pwm", bus.pwm, 0);
    chk("rst_duty", bus.duty, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_fault", bus.fault, 0);
    rst = 1'b1;

    repeat (3) run_period(-1, 0, 0, 0);

    // Dry sample: ramp to 80% over 80 boundaries.
    repeat (82) run_period(50, 1, 0, 15);
    chk("b3_steady", bus.duty, 80);

    run_period(50, 1, 0, 20);
    run_period(50, 1, 0, 21);
    chk("hyst_hold", bus.duty, 80);
    repeat (32) run_period(50, 1, 0, 22);
    chk("b2_steady", bus.duty, 50);
    repeat (52) run_period(50, 1, 0, 65);
    chk("b0_steady", bus.duty, 0);

    repeat (52) run_period(50, 1, 0, 35);
    chk("b2_again", bus.duty, 50);
    run_period(50, 0, 1, 0);
    run_period(-1, 0, 0, 0);
    chk("err_duty0", bus.duty, 0);
    chk("err_fault", bus.fault, 1);
    repeat (5) run_period(50, 1, 0, 35);
    chk("recover_ramp", bus.duty, 5);

    run_period(50, 1, 0, 101);
    run_period(-1, 0, 0, 0);
    chk("over100_fault", bus.state, 2);

    // Stale watchdog: entry period is boundary 1, FAULT lands on boundary 5.
    run_period(50, 1, 0, 35);
    repeat (3) run_period(-1, 0, 0, 0);
    chk("stale_run4", bus.state, 1);
    run_period(-1, 0, 0, 0);
    chk("stale_fault5", bus.state, 2);

    run_period(50, 1, 0, 35);
    run_period(50, 1, 1, 35);
    chk("err_wins", bus.state, 2);

    guard = 0;
    while (m_duty < 34 && guard < 100) begin
      run_period(50, 1, 0, 15);
      guard++;
    end
    chk("pre_rst_duty", bus.duty, 34);
    repeat (30) @(negedge clk);
    chk("pre_rst_pwm", bus.pwm, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_pwm", bus.pwm, 0);
    chk("mid_rst_duty", bus.duty, 0);
    chk("mid_rst_state", bus.state, 0);
    chk("mid_rst_fault", bus.fault, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    exp_st_q.delete();
    exp_duty_q.delete();

    run_period(-1, 0, 0, 0);
    run_period(10, 1, 0, 15);
    run_period(10, 1, 0, 15);
    chk("post_rst_duty", bus.duty, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
